// File: rtl/quad_pkg.sv
// quad_pkg: shared states, phase codes and default timing for the quadrature generator
package quad_pkg;
    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4, GAPW, FIN} state_e;
    localparam int DEF_DWELL = 1000;
    localparam int DEF_GAP = 0;
    localparam logic [1:0] PH_CODE [2][3] = '{'{2'b01, 2'b11, 2'b10}, '{2'b10, 2'b11, 2'b01}};
    function automatic logic [1:0] ph_code(input logic dir, input state_e s);
        return (s == PH1) ? PH_CODE[dir][0] : (s == PH2) ? PH_CODE[dir][1] : (s == PH3) ? PH_CODE[dir][2] : 2'b00;
    endfunction
endpackage

// File: rtl/quad_tick.sv
// quad_tick: loadable down-counter pulsing expire_o in the last cycle of a loaded interval
module quad_tick #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? val_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign expire_o = cnt_q == W'(1);
endmodule

// File: rtl/quad_gen.sv
// quad_gen: emits A/B Gray-code detents for a rotary-encoder decoder from valid/ready commands
module quad_gen import quad_pkg::*; #(
    parameter int DWELL = DEF_DWELL,
    parameter int GAP = DEF_GAP,
    parameter int STEPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [STEPW-1:0] cmd_steps,
    input  logic             abort,
    output logic             ROT_A,
    output logic             ROT_B,
    output logic             busy,
    output logic             done
);
    localparam int TW = $clog2((DWELL > GAP ? DWELL : GAP) + 1);
    localparam logic [TW-1:0] DW = TW'(DWELL);
    localparam logic [TW-1:0] GW = TW'(GAP);
    state_e state_q, state_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic [TW-1:0] load_val;
    logic [1:0] ab_q, ab_d;
    logic dir_q, dir_d, abort_q, abort_d, load, expire, stop;
    quad_tick #(.W(TW)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .val_i   (load_val),
        .expire_o(expire)
    );
    assign stop = abort_q | abort;
    // a zero-step command parks one cycle in GAPW so done lands the cycle after acceptance
    always_comb begin
        state_d = state_q;
        rem_d = rem_q;
        dir_d = dir_q;
        load = 1'b0;
        load_val = DW;
        case (state_q)
            IDLE: if (cmd_valid) begin
                dir_d = cmd_dir;
                rem_d = cmd_steps;
                load = 1'b1;
                state_d = (cmd_steps == '0) ? GAPW : PH1;
                load_val = (cmd_steps == '0) ? TW'(1) : DW;
            end
            PH1, PH2, PH3: if (expire) begin
                state_d = state_e'(state_q + 3'd1);
                load = 1'b1;
            end
            PH4: if (expire) begin
                rem_d = rem_q - STEPW'(1);
                state_d = (rem_d == '0 || stop) ? FIN : (GAP == 0) ? PH1 : GAPW;
                load = state_d != FIN;
                load_val = (GAP == 0) ? DW : GW;
            end
            GAPW: if (expire) begin
                state_d = (rem_q == '0 || stop) ? FIN : PH1;
                load = state_d == PH1;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        abort_d = (state_q == IDLE || state_q == FIN) ? 1'b0 : stop;
        ab_d = ph_code(dir_d, state_d);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q <= '0;
            dir_q <= 1'b0;
            abort_q <= 1'b0;
            ab_q <= 2'b00;
        end else begin
            state_q <= state_d;
            rem_q <= rem_d;
            dir_q <= dir_d;
            abort_q <= abort_d;
            ab_q <= ab_d;
        end
    end
    assign ROT_A = ab_q[1];
    assign ROT_B = ab_q[0];
    assign cmd_ready = state_q == IDLE;
    assign busy = !cmd_ready;
    assign done = state_q == FIN;
endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: directed quad_gen commands checked against a detent-schedule model every cycle
module tb_quad_gen;
    localparam int D = 4, G = 2, L = 4 * D + G;
    logic clk = 0, rst = 1, cmd_valid = 0, cmd_dir = 0, abort = 0;
    logic [7:0] cmd_steps = 0;
    logic rot_a, rot_b, cmd_ready, busy, done;
    int vecs = 0, errs = 0, e = 0, tt = 0, ta = 0, snap = 0, dec = 0;
    bit act = 0, aborted = 0, m_dir = 0;
    int t0 = 0, m_n = 0, m_done = 0, mk, mj, mne, ck;
    logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] prev_ab = 2'b00, x_ab;
    logic x_done, x_rdy;

    quad_gen #(.DWELL(D), .GAP(G), .STEPW(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .abort(abort), .ROT_A(rot_a), .ROT_B(rot_b), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // model: a command of N detents occupies N*(4D+G)-G cycles, then one done cycle
    always @(posedge clk or posedge rst) begin
        if (rst) act = 0;
        else begin
            e = e + 1;
            if (!act || e - 1 > t0 + m_done) begin
                if (cmd_valid) begin
                    act = 1; aborted = 0; t0 = e; m_dir = cmd_dir; m_n = int'(cmd_steps);
                    m_done = (m_n == 0) ? 1 : m_n * 4 * D + (m_n - 1) * G;
                end
            end else if (abort && !aborted && m_n > 0 && e - 1 - t0 < m_done) begin
                aborted = 1;
                mk = e - 1 - t0; mj = mk / L;
                mne = (m_n < mj + 1) ? m_n : mj + 1;
                m_done = (mk % L < 4 * D) ? mne * 4 * D + (mne - 1) * G : (mj + 1) * L;
            end
        end
    end

    function automatic logic [1:0] exp_ab(input int k);
        logic [1:0] c;
        if (!act || k >= m_done || m_n == 0 || k % L >= 4 * D) return 2'b00;
        c = up_seq[(k % L) / D];
        return m_dir ? c : {c[0], c[1]};
    endfunction

    always @(negedge clk) begin
        ck = e - t0;
        x_ab = exp_ab(ck);
        x_done = act && ck == m_done;
        x_rdy = !act || ck > m_done;
        vecs++;
        if ({rot_a, rot_b, done, cmd_ready, busy} !== {x_ab, x_done, x_rdy, !x_rdy}) begin
            errs++;
            $display("FAIL model k=%0d got ab=%b%b done=%b rdy=%b busy=%b want ab=%b done=%b rdy=%b",
                     ck, rot_a, rot_b, done, cmd_ready, busy, x_ab, x_done, x_rdy);
        end
    end

    always @(negedge clk) begin
        if (prev_ab == 2'b01 && {rot_a, rot_b} == 2'b00) dec++;
        if (prev_ab == 2'b10 && {rot_a, rot_b} == 2'b00) dec--;
        prev_ab = {rot_a, rot_b};
    end

    task automatic check(input string name, input int got, input int want);
        vecs++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic at_cycle(input int k);
        int w = 0;
        while (e < tt + k && w < 1000) begin @(posedge clk); #1; w++; end
        if (w >= 1000) check("cycle wait timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send(input logic d, input int n);
        logic r;
        int w = 0;
        cmd_dir = d; cmd_steps = 8'(n); cmd_valid = 1;
        do begin r = cmd_ready; @(posedge clk); #1; w++; end while (!r && w < 1000);
        if (!r) check("accept timeout", 0, 1);
        cmd_valid = 0; tt = e;
    endtask

    task automatic single_up(input string tag);
        snap = dec;
        send(1, 1);
        at_cycle(0);  check({tag, " ph1"}, {rot_a, rot_b}, 2);
        at_cycle(4);  check({tag, " ph2"}, {rot_a, rot_b}, 3);
        at_cycle(8);  check({tag, " ph3"}, {rot_a, rot_b}, 1);
        at_cycle(12); check({tag, " ph4"}, {rot_a, rot_b}, 0); check({tag, " no done"}, done, 0);
        at_cycle(16); check({tag, " done"}, done, 1);
        at_cycle(17); check({tag, " ready"}, cmd_ready, 1); check({tag, " count"}, dec - snap, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset ab", {rot_a, rot_b}, 0);
        check("reset ready", cmd_ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        single_up("up");
        snap = dec;
        send(0, 3);
        at_cycle(0);  check("down ph1", {rot_a, rot_b}, 1);
        at_cycle(16); check("down gap", {rot_a, rot_b}, 0);
        at_cycle(18); check("down 2nd ph1", {rot_a, rot_b}, 1);
        at_cycle(51); check("down no done", done, 0);
        at_cycle(52); check("down done", done, 1);
        at_cycle(53); check("down count", dec - snap, -3);
        send(1, 0);
        at_cycle(0); check("zero ready", cmd_ready, 0); check("zero ab", {rot_a, rot_b}, 0);
        at_cycle(1); check("zero done", done, 1); check("zero ready2", cmd_ready, 0);
        at_cycle(2); check("zero ready back", cmd_ready, 1); check("zero done off", done, 0);
        snap = dec;
        send(1, 10);
        while (e < tt + 21) begin @(posedge clk); #1; end
        abort = 1;
        @(posedge clk); #1 abort = 0;
        at_cycle(33); check("abort no done", done, 0);
        at_cycle(34); check("abort done", done, 1);
        at_cycle(36); check("abort count", dec - snap, 2);
        send(1, 1);
        ta = tt;
        send(0, 2);
        check("b2b accept edge", tt - ta, 18);
        at_cycle(0); check("b2b ph1", {rot_a, rot_b}, 1);
        at_cycle(35); check("b2b ready", cmd_ready, 1);
        send(1, 1);
        at_cycle(5); check("pre-reset ab", {rot_a, rot_b}, 3);
        #2 rst = 1;
        #1 check("async reset ab", {rot_a, rot_b}, 0);
        check("async reset ready", cmd_ready, 1);
        check("async reset busy", busy, 0);
        #1 rst = 0;
        @(negedge clk);
        single_up("post-reset");
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
